vadd_seq_ctrl: RTL and testbench

Sequencing controller for the lab's 4-bit adder / seven-segment datapath. It captures two operands from the switches with a debounced button and computes a 5-bit sum with carry-out. Results can be chained, so each sum becomes the next first operand. It also time-multiplexes A, B, sum and live switches onto a 4-digit active-low seven-segment display. It sits between the board I/O (switches, buttons, display) and replaces the purely combinational adder-to-display path.

---
 rtl/vadd_seq_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_vadd_seq_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vadd_seq_ctrl.sv
// vadd_seq_ctrl: operand capture, 4+4 add with chaining, and a 4-digit
// active-low seven-segment scan for the lab adder board.
// Ports: clk, rst_n (async active-low), sw[3:0], btn_enter, btn_clr (raw),
//        seg_L[6:0] {g..a}, an_L[3:0], oflow, state_led[1:0].
module vadd_seq_ctrl #(
  parameter int REFRESH_DIV = 16,
  parameter int DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clr,
  output logic [6:0] seg_L,
  output logic [3:0] an_L,
  output logic       oflow,
  output logic [1:0] state_led
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {
    GET_A = 2'b00,
    GET_B = 2'b01,
    SHOW  = 2'b10,
    ILL   = 2'b11
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_a;
  logic [3:0]      r_b;
  logic [4:0]      r_s;
  logic            r_of;
  logic [3:0]      w_a_nxt;
  logic [3:0]      w_b_nxt;
  logic [4:0]      w_s_nxt;
  logic            w_of_nxt;
  logic [4:0]      w_sum;

  logic            r_ent_s1;
  logic            r_ent_s2;
  logic            r_clr_s1;
  logic            r_clr_s2;
  logic [DW-1:0]   r_dbc;
  logic            r_press;

  logic [RW-1:0]   r_ref;
  logic [1:0]      r_dig;
  logic [3:0]      w_nib;
  logic            w_blank;
  logic [6:0]      w_hex;

  // two-flop synchronisers for both raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent_s1 <= 1'b0;
      r_ent_s2 <= 1'b0;
      r_clr_s1 <= 1'b0;
      r_clr_s2 <= 1'b0;
    end else begin
      r_ent_s1 <= btn_enter;
      r_ent_s2 <= r_ent_s1;
      r_clr_s1 <= btn_clr;
      r_clr_s2 <= r_clr_s1;
    end
  end

  // press is registered on the D-1 -> D step, so it is seen
  // one cycle after the counter saturates; saturation gives
  // one press per high period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbc   <= '0;
      r_press <= 1'b0;
    end else if (r_clr_s2 || !r_ent_s2) begin
      r_dbc   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= (r_dbc == DW'(DEBOUNCE - 1));
      if (r_dbc != DW'(DEBOUNCE))
        r_dbc <= r_dbc + 1'b1;
    end
  end

  // sum uses live sw so S is valid the same edge B captures
  assign w_sum = {1'b0, r_a} + {1'b0, sw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= GET_A;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_of    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_s     <= w_s_nxt;
      r_of    <= w_of_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_s_nxt     = r_s;
    w_of_nxt    = r_of;
    if (r_clr_s2) begin
      w_state_nxt = GET_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_s_nxt     = '0;
      w_of_nxt    = 1'b0;
    end else begin
      unique case (r_state)
        GET_A: begin
          if (r_press) begin
            w_a_nxt     = sw;
            w_state_nxt = GET_B;
          end
        end
        GET_B: begin
          if (r_press) begin
            w_b_nxt     = sw;
            w_s_nxt     = w_sum;
            w_of_nxt    = w_sum[4];
            w_state_nxt = SHOW;
          end
        end
        SHOW: begin
          if (r_press) begin
            w_a_nxt     = r_s[3:0];
            w_b_nxt     = '0;
            w_state_nxt = GET_B;
          end
        end
        default: w_state_nxt = GET_A;
      endcase
    end
  end

  // scan runs independently of clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref <= '0;
      r_dig <= 2'd3;
    end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
      r_ref <= '0;
      r_dig <= r_dig - 2'd1;
    end else begin
      r_ref <= r_ref + 1'b1;
    end
  end

  always_comb begin
    an_L    = 4'b0111;
    w_nib   = r_a;
    w_blank = 1'b0;
    unique case (r_dig)
      2'd3: begin
        an_L  = 4'b0111;
        w_nib = r_a;
      end
      2'd2: begin
        an_L  = 4'b1011;
        w_nib = r_b;
      end
      2'd1: begin
        an_L    = 4'b1101;
        w_nib   = r_s[3:0];
        w_blank = (r_state != SHOW);
      end
      default: begin
        an_L  = 4'b1110;
        w_nib = sw;
      end
    endcase
  end

  always_comb begin
    w_hex = 7'b1111111;
    unique case (w_nib)
      4'h0: w_hex = 7'b1000000;
      4'h1: w_hex = 7'b1111001;
      4'h2: w_hex = 7'b0100100;
      4'h3: w_hex = 7'b0110000;
      4'h4: w_hex = 7'b0011001;
      4'h5: w_hex = 7'b0010010;
      4'h6: w_hex = 7'b0000010;
      4'h7: w_hex = 7'b1111000;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0010000;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b0000011;
      4'hC: w_hex = 7'b1000110;
      4'hD: w_hex = 7'b0100001;
      4'hE: w_hex = 7'b0000110;
      default: w_hex = 7'b0001110;
    endcase
  end

  assign seg_L     = w_blank ? 7'b1111111 : w_hex;
  assign oflow     = r_of;
  assign state_led = r_state;

endmodule

// File: tb/tb_vadd_seq_ctrl.sv
// tb_vadd_seq_ctrl: table-driven vectors plus hand sequences for
// reset, scan, debounce, clear priority and live digit 0.
module tb_vadd_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       btn_enter;
  logic       btn_clr;
  logic [6:0] seg_L;
  logic [3:0] an_L;
  logic       oflow;
  logic [1:0] state_led;

  int n_vec = 0;
  int n_err = 0;

  vadd_seq_ctrl #(.REFRESH_DIV(16), .DEBOUNCE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_enter (btn_enter),
    .btn_clr   (btn_clr),
    .seg_L     (seg_L),
    .an_L      (an_L),
    .oflow     (oflow),
    .state_led (state_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         clr;
    logic [3:0] sw;
    logic [1:0] st;
    logic       of;
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
  } vec_t;

  vec_t tv[14];

  task automatic chk(string nm, logic [6:0] act, logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_dig(string nm, logic [3:0] an, logic [6:0] exp);
    int k;
    k = 0;
    while (an_L !== an && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout got an_L %b want %b", nm, an_L, an);
    end else begin
      chk(nm, seg_L, exp);
    end
  endtask

  task automatic press(logic [3:0] v);
    sw = v;
    btn_enter = 1'b1;
    repeat (10) @(negedge clk);
    btn_enter = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic clear();
    btn_clr = 1'b1;
    repeat (4) @(negedge clk);
    btn_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_with_enter(string nm, logic [1:0] st_before);
    btn_clr   = 1'b1;
    btn_enter = 1'b1;
    repeat (2) @(negedge clk);
    chk({nm, "_st_2edges"}, {5'd0, state_led}, {5'd0, st_before});
    @(negedge clk);
    chk({nm, "_st_3edges"}, {5'd0, state_led}, 7'd0);
    chk({nm, "_of_3edges"}, {6'd0, oflow}, 7'd0);
    repeat (10) @(negedge clk);
    btn_clr   = 1'b0;
    btn_enter = 1'b0;
    repeat (10) @(negedge clk);
    chk({nm, "_st_after"}, {5'd0, state_led}, 7'd0);
    chk_dig({nm, "_d3"}, 4'b0111, 7'b1000000);
    chk_dig({nm, "_d2"}, 4'b1011, 7'b1000000);
    chk_dig({nm, "_d1"}, 4'b1101, 7'b1111111);
  endtask

  initial begin
    tv[0]  = '{0, 4'h3, 2'b01, 0, 7'b0110000, 7'b1000000, 7'b1111111};
    tv[1]  = '{0, 4'h4, 2'b10, 0, 7'b0110000, 7'b0011001, 7'b1111000};
    tv[2]  = '{0, 4'h0, 2'b01, 0, 7'b1111000, 7'b1000000, 7'b1111111};
    tv[3]  = '{0, 4'h9, 2'b10, 1, 7'b1111000, 7'b0010000, 7'b1000000};
    tv[4]  = '{0, 4'h2, 2'b01, 1, 7'b1000000, 7'b1000000, 7'b1111111};
    tv[5]  = '{0, 4'hF, 2'b10, 0, 7'b1000000, 7'b0001110, 7'b0001110};
    tv[6]  = '{1, 4'h0, 2'b00, 0, 7'b1000000, 7'b1000000, 7'b1111111};
    tv[7]  = '{0, 4'h9, 2'b01, 0, 7'b0010000, 7'b1000000, 7'b1111111};
    tv[8]  = '{0, 4'h8, 2'b10, 1, 7'b0010000, 7'b0000000, 7'b1111001};
    tv[9]  = '{1, 4'h0, 2'b00, 0, 7'b1000000, 7'b1000000, 7'b1111111};
    tv[10] = '{0, 4'h5, 2'b01, 0, 7'b0010010, 7'b1000000, 7'b1111111};
    tv[11] = '{0, 4'h5, 2'b10, 0, 7'b0010010, 7'b0010010, 7'b0001000};
    tv[12] = '{0, 4'h0, 2'b01, 0, 7'b0001000, 7'b1000000, 7'b1111111};
    tv[13] = '{0, 4'h7, 2'b10, 1, 7'b0001000, 7'b1111000, 7'b1111001};

    rst_n     = 1'b0;
    sw        = 4'h0;
    btn_enter = 1'b0;
    btn_clr   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sw        = 4'(i * 5);
      btn_enter = i[0];
      btn_clr   = ~i[0];
    end
    @(negedge clk);
    chk("rst_an", {3'd0, an_L}, 7'b0000111);
    chk("rst_seg", seg_L, 7'b1000000);
    chk("rst_of", {6'd0, oflow}, 7'd0);
    chk("rst_st", {5'd0, state_led}, 7'd0);

    btn_enter = 1'b0;
    btn_clr   = 1'b0;
    sw        = 4'h0;
    rst_n     = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1)  chk("scan_1",  {3'd0, an_L}, 7'b0000111);
      if (k == 15) chk("scan_15", {3'd0, an_L}, 7'b0000111);
      if (k == 16) chk("scan_16", {3'd0, an_L}, 7'b0001011);
      if (k == 32) chk("scan_32", {3'd0, an_L}, 7'b0001101);
      if (k == 48) chk("scan_48", {3'd0, an_L}, 7'b0001110);
      if (k == 64) chk("scan_64", {3'd0, an_L}, 7'b0000111);
    end

    for (int i = 0; i < 14; i++) begin
      if (tv[i].clr) clear();
      else press(tv[i].sw);
      chk($sformatf("v%0d_st", i), {5'd0, state_led}, {5'd0, tv[i].st});
      chk($sformatf("v%0d_of", i), {6'd0, oflow}, {6'd0, tv[i].of});
      chk_dig($sformatf("v%0d_d3", i), 4'b0111, tv[i].d3);
      chk_dig($sformatf("v%0d_d2", i), 4'b1011, tv[i].d2);
      chk_dig($sformatf("v%0d_d1", i), 4'b1101, tv[i].d1);
    end

    // clear together with enter while in SHOW with oflow set
    clr_with_enter("clr_show", 2'b10);

    // clear together with enter while in GET_B
    press(4'h6);
    chk("getb_st", {5'd0, state_led}, 7'b0000001);
    clr_with_enter("clr_getb", 2'b01);

    // short pulse: 3 synchronised high cycles -> no press
    sw = 4'h2;
    btn_enter = 1'b1;
    repeat (3) @(negedge clk);
    btn_enter = 1'b0;
    repeat (8) @(negedge clk);
    chk("dbc_short_st", {5'd0, state_led}, 7'd0);

    // long hold -> exactly one transition
    btn_enter = 1'b1;
    repeat (100) @(negedge clk);
    chk("dbc_long_st", {5'd0, state_led}, 7'b0000001);
    btn_enter = 1'b0;
    repeat (8) @(negedge clk);
    chk("dbc_long_st2", {5'd0, state_led}, 7'b0000001);
    chk_dig("dbc_long_d3", 4'b0111, 7'b0100100);

    // digit 0 follows sw within the cycle
    chk_dig("live_d0_a", 4'b1110, 7'b0100100);
    #1;
    sw = 4'hA;
    #1;
    chk("live_d0_b", seg_L, 7'b0001000);
    sw = 4'hd;
    #1;
    chk("live_d0_c", seg_L, 7'b0100001);

    // asynchronous reset mid-operation
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_st", {5'd0, state_led}, 7'd0);
    chk("arst_an", {3'd0, an_L}, 7'b0000111);
    chk("arst_seg", seg_L, 7'b1000000);
    chk("arst_of", {6'd0, oflow}, 7'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
